sdr_multibank_model: RTL
========================

SDR_MULTIBANK_MODEL -- requirements
Module: sdr_multibank_model

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning DQ width (4, 8 or 16 only).
REQ-002 SHALL have parameter NUM_BANK, default 4, meaning bank count (power of two); BA width = log2(NUM_BANK).
REQ-003 SHALL have parameter ROW_WIDTH, default 12, meaning row address width (equals A width).
REQ-004 SHALL have parameter COL_WIDTH, default 9, meaning column address width taken from A[COL_WIDTH-1:0] (A[10] excluded when COL_WIDTH>10).
REQ-005 SHALL have parameter MEM_AW, default 12, meaning storage index width; index = {bank, row, col} truncated to the low MEM_AW bits.
REQ-006 SHALL have parameters T_RCD, default 2, and T_RP, default 2, meaning minimum cycles from ACTIVATE to READ/WRITE and from PRECHARGE to ACTIVATE.
REQ-007 Ports: sdr_CK in 1 clock; sdr_RSTn in 1 reset; sdr_CKE in 1 clock enable; sdr_CSn, sdr_RASn, sdr_CASn, sdr_WEn in 1 each, command; sdr_A in ROW_WIDTH address; sdr_BA in log2(NUM_BANK) bank; sdr_DQM in 1 data mask; sdr_DQ_i in DATA_WIDTH write data; sdr_DQ_o out DATA_WIDTH read data; sdr_DQ_oe out 1 read drive enable; cmd_err out 1 illegal-command pulse; timing_err out 1 timing-violation pulse; wr_count out 16 beats written; rd_count out 16 beats read.
REQ-008 SHALL use the single clock sdr_CK (rising edge) and sdr_RSTn, asynchronous, active-low.

Function
REQ-009 Commands decode from {CSn,RASn,CASn,WEn} on each rising edge: 0000 LOAD MODE, 0001 REFRESH, 0010 PRECHARGE, 0011 ACTIVATE, 0100 WRITE, 0101 READ, 0110 BURST TERMINATE, 0111 NOP; CSn=1 is NOP.
REQ-010 sdr_CKE low SHALL freeze all state, counters and outputs for that edge (clock suspend); the command is ignored.
REQ-011 LOAD MODE: CL = A[6:4] (2 or 3 accepted), BL = A[2:0] (000/001/010/011 -> 1/2/4/8); other encodings or any bank open -> cmd_err, mode unchanged.
REQ-012 Per-bank state: closed/open plus open-row register; ACTIVATE to an open bank -> cmd_err, ignored; PRECHARGE with A[10]=1 closes all banks, else bank BA only.
REQ-013 READ/WRITE to a closed bank -> cmd_err, ignored; REFRESH with any bank open -> cmd_err.
REQ-014 Control FSM states IDLE, WR_BURST, RD_LAT, RD_BURST; reset state IDLE.
REQ-015 WRITE at edge n stores sdr_DQ_i as beat 0 at edge n; beats 1..BL-1 stored at edges n+1..n+BL-1 (WR_BURST); then IDLE.
REQ-016 READ at edge n: beat 0 registered onto sdr_DQ_o with sdr_DQ_oe=1 at edge n+CL-1 (sampled by controller at edge n+CL); remaining beats on consecutive edges; sdr_DQ_oe drops the edge after the last beat.
REQ-017 Burst column order SHALL be sequential, wrapping inside the BL-aligned block (start col 6, BL=4 -> 6,7,4,5).
REQ-018 sdr_DQM=1 at a write beat edge suppresses that store (counter still increments); at a read beat edge forces sdr_DQ_oe=0 for that beat.
REQ-019 New READ/WRITE during a burst or latency SHALL terminate the old burst and start the new one at that edge; BURST TERMINATE or PRECHARGE of the burst bank ends it immediately (sdr_DQ_oe=0 next edge).
REQ-020 wr_count/rd_count increment once per write/read beat, wrap at 16 bits; cmd_err/timing_err are single-cycle registered pulses.

Reset
REQ-021 On sdr_RSTn low: FSM IDLE, all banks closed, CL=2, BL=1, sdr_DQ_o=0, sdr_DQ_oe=0, cmd_err=0, timing_err=0, counters 0; storage contents undefined; reset mid-burst aborts the burst.

Configuration
REQ-022 With SDR_TIMING_CHECK_EN defined, per-bank counters SHALL pulse timing_err on READ/WRITE earlier than T_RCD after ACTIVATE or ACTIVATE earlier than T_RP after PRECHARGE; the command still executes.
REQ-023 Without SDR_TIMING_CHECK_EN, timing_err SHALL be tied 0 and no timing counters exist.

Structure
REQ-024 Package sdr_pkg SHALL hold command encodings, FSM state enum and burst-length decode function.
REQ-025 Sub-module sdr_bank_state SHALL implement one bank's open flag, row register and optional timing counter, instantiated NUM_BANK times.

Verification
REQ-026 LOAD MODE 0x032, ACTIVATE b1 r0x05, WRITE col 0 data 1,2,3,4, READ col 0 -> DQ 1,2,3,4 sampled edges n+3..n+6, wr_count=rd_count=4.
REQ-027 BL=4 write col 6 data A,B,C,D, read col 4 -> C,D,A,B.
REQ-028 READ to closed bank 2 -> cmd_err one cycle, sdr_DQ_oe stays 0, rd_count unchanged.
REQ-029 Write BL=4 with DQM=1 on beat 2, read back -> beat 2 holds prior contents; read with DQM on beat 1 -> sdr_DQ_oe=0 that cycle only.
REQ-030 With SDR_TIMING_CHECK_EN: ACTIVATE then READ next cycle (T_RCD=2) -> timing_err pulse, data still returned.
REQ-031 Assert sdr_RSTn low mid read burst -> sdr_DQ_oe=0 immediately, all banks closed, CL=2, BL=1.

Source files
------------

// File: rtl/sdr_pkg.sv
// Shared command encodings, controller states and mode decode for the SDR SDRAM model.
package sdr_pkg;

    typedef enum logic [3:0] {
        CMD_LMR = 4'b0000,
        CMD_REF = 4'b0001,
        CMD_PRE = 4'b0010,
        CMD_ACT = 4'b0011,
        CMD_WR  = 4'b0100,
        CMD_RD  = 4'b0101,
        CMD_BST = 4'b0110,
        CMD_NOP = 4'b0111
    } sdr_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_BURST,
        ST_RD_LAT,
        ST_RD_BURST
    } sdr_state_e;

    // Mode-register BL field 000/001/010/011 -> 1/2/4/8 beats.
    function automatic logic [3:0] bl_decode(input logic [1:0] code);
        return 4'd1 << code;
    endfunction

endpackage

// File: rtl/sdr_bank_state.sv
// One SDRAM bank: open flag, open-row register and, with SDR_TIMING_CHECK_EN,
// a tRCD/tRP guard counter.
module sdr_bank_state
    import sdr_pkg::*;
#(
    parameter int ROW_WIDTH = 12
`ifdef SDR_TIMING_CHECK_EN
    ,
    parameter int unsigned T_RCD = 2,
    parameter int unsigned T_RP  = 2
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cke,
    input  logic                 act,
    input  logic                 pre,
    input  logic [ROW_WIDTH-1:0] row_in,
`ifdef SDR_TIMING_CHECK_EN
    output logic                 busy,
`endif
    output logic                 is_open,
    output logic [ROW_WIDTH-1:0] row
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_open <= 1'b0;
            row     <= '0;
        end else if (cke) begin
            if (pre) begin
                is_open <= 1'b0;
            end else if (act) begin
                is_open <= 1'b1;
                row     <= row_in;
            end
        end
    end

`ifdef SDR_TIMING_CHECK_EN
    logic [7:0] tcnt;

    // Counter holds the remaining cycles before the next command is legal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
        end else if (cke) begin
            if (act)
                tcnt <= 8'((T_RCD > 0) ? T_RCD - 1 : 0);
            else if (pre)
                tcnt <= 8'((T_RP > 0) ? T_RP - 1 : 0);
            else if (tcnt != '0)
                tcnt <= tcnt - 8'd1;
        end
    end

    assign busy = (tcnt != '0);
`endif

endmodule

// File: rtl/sdr_multibank_model.sv
// Multi-bank SDR SDRAM behavioural model with burst read/write and command checking.
// Optional tRCD/tRP violation reporting is enabled by defining SDR_TIMING_CHECK_EN.
module sdr_multibank_model
    import sdr_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_BANK   = 4,
    parameter int ROW_WIDTH  = 12,
    parameter int COL_WIDTH  = 9,
    parameter int MEM_AW     = 12,
    parameter int T_RCD      = 2,
    parameter int T_RP       = 2
) (
    input  logic                         sdr_CK,
    input  logic                         sdr_RSTn,
    input  logic                         sdr_CKE,
    input  logic                         sdr_CSn,
    input  logic                         sdr_RASn,
    input  logic                         sdr_CASn,
    input  logic                         sdr_WEn,
    input  logic [ROW_WIDTH-1:0]         sdr_A,
    input  logic [$clog2(NUM_BANK)-1:0]  sdr_BA,
    input  logic                         sdr_DQM,
    input  logic [DATA_WIDTH-1:0]        sdr_DQ_i,
    output logic [DATA_WIDTH-1:0]        sdr_DQ_o,
    output logic                         sdr_DQ_oe,
    output logic                         cmd_err,
    output logic                         timing_err,
    output logic [15:0]                  wr_count,
    output logic [15:0]                  rd_count
);

    localparam int BA_W = $clog2(NUM_BANK);

    sdr_cmd_e              cmd;
    sdr_state_e            state, state_nxt;
    logic [NUM_BANK-1:0]   bank_open, bank_act, bank_pre;
    logic [ROW_WIDTH-1:0]  bank_row [NUM_BANK];
    logic [COL_WIDTH-1:0]  col_addr, cur_col;
    logic [2:0]            cl;
    logic [3:0]            bl;
    logic [2:0]            beat, beat_nxt;
    logic [1:0]            lat, lat_nxt;
    logic [BA_W-1:0]       bst_bank, bst_bank_nxt;
    logic [ROW_WIDTH-1:0]  bst_row, bst_row_nxt;
    logic [COL_WIDTH-1:0]  bst_col, bst_col_nxt;
    logic                  sel_open, any_open, lmr_ok, start_rw, kill, last_beat;
    logic                  err_nxt, mem_we, wr_beat, rd_out;
    logic [MEM_AW-1:0]     wr_idx, burst_idx;
    logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

    // Sequential order wrapping inside the BL-aligned column block.
    function automatic logic [COL_WIDTH-1:0] burst_col(input logic [COL_WIDTH-1:0] base,
                                                       input logic [2:0]           idx,
                                                       input logic [3:0]           len);
        logic [COL_WIDTH-1:0] mask;
        mask = COL_WIDTH'(len - 4'd1);
        return (base & ~mask) | ((base + COL_WIDTH'(idx)) & mask);
    endfunction

    assign cmd = sdr_CSn ? CMD_NOP : sdr_cmd_e'({1'b0, sdr_RASn, sdr_CASn, sdr_WEn});

    // A[10] is the auto-precharge bit, so wide column addresses skip over it.
    for (genvar gi = 0; gi < COL_WIDTH; gi++) begin : g_col
        if (gi < 10) begin : g_lo
            assign col_addr[gi] = sdr_A[gi];
        end else begin : g_hi
            assign col_addr[gi] = sdr_A[gi + 1];
        end
    end

`ifdef SDR_TIMING_CHECK_EN
    logic [NUM_BANK-1:0] bank_busy;
`endif

    for (genvar gb = 0; gb < NUM_BANK; gb++) begin : g_bank
        assign bank_act[gb] = (cmd == CMD_ACT) && (sdr_BA == BA_W'(gb)) && !bank_open[gb];
        assign bank_pre[gb] = (cmd == CMD_PRE) && (sdr_A[10] || (sdr_BA == BA_W'(gb)));

        sdr_bank_state #(
            .ROW_WIDTH (ROW_WIDTH)
`ifdef SDR_TIMING_CHECK_EN
            ,
            .T_RCD     (T_RCD),
            .T_RP      (T_RP)
`endif
        ) u_bank (
            .clk     (sdr_CK),
            .rst_n   (sdr_RSTn),
            .cke     (sdr_CKE),
            .act     (bank_act[gb]),
            .pre     (bank_pre[gb]),
            .row_in  (sdr_A),
`ifdef SDR_TIMING_CHECK_EN
            .busy    (bank_busy[gb]),
`endif
            .is_open (bank_open[gb]),
            .row     (bank_row[gb])
        );
    end

    always_comb begin
        sel_open  = bank_open[sdr_BA];
        any_open  = |bank_open;
        lmr_ok    = ((sdr_A[6:4] == 3'd2) || (sdr_A[6:4] == 3'd3)) && !sdr_A[2] && !any_open;
        start_rw  = ((cmd == CMD_RD) || (cmd == CMD_WR)) && sel_open;
        kill      = (state != ST_IDLE) &&
                    ((cmd == CMD_BST) || ((cmd == CMD_PRE) && (sdr_A[10] || (sdr_BA == bst_bank))));
        last_beat = ({1'b0, beat} == (bl - 4'd1));
        cur_col   = burst_col(bst_col, beat, bl);
        burst_idx = MEM_AW'({bst_bank, bst_row, cur_col});
        case (cmd)
            CMD_LMR:        err_nxt = !lmr_ok;
            CMD_REF:        err_nxt = any_open;
            CMD_ACT:        err_nxt = sel_open;
            CMD_RD, CMD_WR: err_nxt = !sel_open;
            default:        err_nxt = 1'b0;
        endcase
    end

    // A valid READ/WRITE always wins, cutting short whatever burst is running.
    always_comb begin
        state_nxt    = state;
        beat_nxt     = beat;
        lat_nxt      = lat;
        bst_bank_nxt = bst_bank;
        bst_row_nxt  = bst_row;
        bst_col_nxt  = bst_col;
        wr_beat      = 1'b0;
        rd_out       = 1'b0;
        wr_idx       = burst_idx;
        if (start_rw) begin
            bst_bank_nxt = sdr_BA;
            bst_row_nxt  = bank_row[sdr_BA];
            bst_col_nxt  = col_addr;
            if (cmd == CMD_WR) begin
                wr_beat   = 1'b1;
                wr_idx    = MEM_AW'({sdr_BA, bank_row[sdr_BA], col_addr});
                beat_nxt  = 3'd1;
                state_nxt = (bl == 4'd1) ? ST_IDLE : ST_WR_BURST;
            end else begin
                beat_nxt  = '0;
                lat_nxt   = 2'(cl - 3'd2);
                state_nxt = ST_RD_LAT;
            end
        end else if (kill) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_WR_BURST: begin
                    wr_beat  = 1'b1;
                    beat_nxt = beat + 3'd1;
                    if (last_beat)
                        state_nxt = ST_IDLE;
                end
                ST_RD_LAT: begin
                    if (lat == '0) begin
                        rd_out    = 1'b1;
                        beat_nxt  = 3'd1;
                        state_nxt = last_beat ? ST_IDLE : ST_RD_BURST;
                    end else begin
                        lat_nxt = lat - 2'd1;
                    end
                end
                ST_RD_BURST: begin
                    rd_out   = 1'b1;
                    beat_nxt = beat + 3'd1;
                    if (last_beat)
                        state_nxt = ST_IDLE;
                end
                default: ;
            endcase
        end
        mem_we = wr_beat && !sdr_DQM;
    end

    always_ff @(posedge sdr_CK or negedge sdr_RSTn) begin
        if (!sdr_RSTn)
            state <= ST_IDLE;
        else if (sdr_CKE)
            state <= state_nxt;
    end

    always_ff @(posedge sdr_CK or negedge sdr_RSTn) begin
        if (!sdr_RSTn) begin
            beat      <= '0;
            lat       <= '0;
            bst_bank  <= '0;
            bst_row   <= '0;
            bst_col   <= '0;
            cl        <= 3'd2;
            bl        <= 4'd1;
            sdr_DQ_o  <= '0;
            sdr_DQ_oe <= 1'b0;
            cmd_err   <= 1'b0;
            wr_count  <= '0;
            rd_count  <= '0;
        end else if (sdr_CKE) begin
            beat     <= beat_nxt;
            lat      <= lat_nxt;
            bst_bank <= bst_bank_nxt;
            bst_row  <= bst_row_nxt;
            bst_col  <= bst_col_nxt;
            cmd_err  <= err_nxt;
            if ((cmd == CMD_LMR) && lmr_ok) begin
                cl <= sdr_A[6:4];
                bl <= bl_decode(sdr_A[1:0]);
            end
            if (rd_out) begin
                sdr_DQ_o  <= mem[burst_idx];
                sdr_DQ_oe <= !sdr_DQM;
                rd_count  <= rd_count + 16'd1;
            end else begin
                sdr_DQ_oe <= 1'b0;
            end
            if (wr_beat)
                wr_count <= wr_count + 16'd1;
        end
    end

    always_ff @(posedge sdr_CK) begin
        if (sdr_CKE && mem_we)
            mem[wr_idx] <= sdr_DQ_i;
    end

`ifdef SDR_TIMING_CHECK_EN
    logic tim_nxt;
    assign tim_nxt = bank_busy[sdr_BA] && (start_rw || ((cmd == CMD_ACT) && !sel_open));

    always_ff @(posedge sdr_CK or negedge sdr_RSTn) begin
        if (!sdr_RSTn)
            timing_err <= 1'b0;
        else if (sdr_CKE)
            timing_err <= tim_nxt;
    end
`else
    assign timing_err = 1'b0;
`endif

endmodule
